// File: rtl/gb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gb_pkg : constants and types shared by the Game Boy LCD capture and VGA scan-out
// Rev 1.0
// ----------------------------------------------------------------------------
package gb_pkg;

  localparam int GB_H_PIXELS = 160;
  localparam int GB_V_LINES  = 144;
  localparam int FB_ADDR_W   = 15;
  localparam int FB_DEPTH    = GB_H_PIXELS * GB_V_LINES;

  typedef logic [1:0] pixel_t;

  typedef enum logic [0:0] {
    WAIT_FRAME = 1'b0,
    ACTIVE     = 1'b1
  } cap_state_e;

endpackage : gb_pkg
`default_nettype wire

// File: rtl/gb_sync_edge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gb_sync_edge : multi-stage synchroniser with registered rise/fall detect and
//                an equally delayed side lane for level signals
// Rev 1.0
// ----------------------------------------------------------------------------
module gb_sync_edge
  import gb_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sig_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              rise_o,
  output logic              fall_o,
  output logic [DATA_W-1:0] data_o
);

  logic [STAGES-1:0]             sig_q;
  logic [STAGES-1:0][DATA_W-1:0] data_q;
  logic                          sig_prev_q;

  // data_o leaves the same stage as the edge pulse so a pixel pairs with its cp edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q      <= '0;
      data_q     <= '0;
      sig_prev_q <= 1'b0;
      rise_o     <= 1'b0;
      fall_o     <= 1'b0;
      data_o     <= '0;
    end else begin
      sig_q      <= {sig_q[STAGES-2:0], sig_i};
      data_q     <= {data_q[STAGES-2:0], data_i};
      sig_prev_q <= sig_q[STAGES-1];
      rise_o     <= sig_q[STAGES-1] & ~sig_prev_q;
      fall_o     <= ~sig_q[STAGES-1] & sig_prev_q;
      data_o     <= data_q[STAGES-1];
    end
  end

endmodule : gb_sync_edge
`default_nettype wire

// File: rtl/gb_lcd_capture.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gb_lcd_capture : samples the Game Boy LCD bus and produces framebuffer writes
// Rev 1.0
// ----------------------------------------------------------------------------
module gb_lcd_capture
  import gb_pkg::*;
#(
  parameter int H_PIXELS    = GB_H_PIXELS,
  parameter int V_LINES     = GB_V_LINES,
  parameter int ADDR_W      = FB_ADDR_W,
  parameter int SYNC_STAGES = 2,
  parameter int INVERT_DATA = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gb_cp,
  input  logic              gb_hs,
  input  logic              gb_vs,
  input  logic [1:0]        gb_d,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        wr_data,
  output logic              wr_en,
  output logic              frame_done,
  output logic              capturing,
  output logic              line_err,
  output logic              frame_err
);

  localparam int XW = $clog2(H_PIXELS + 2);
  localparam int YW = $clog2(V_LINES + 1);
  localparam logic [XW-1:0]     X_FULL    = XW'(H_PIXELS);
  localparam logic [XW-1:0]     X_SAT     = XW'(H_PIXELS + 1);
  localparam logic [YW-1:0]     Y_LAST    = YW'(V_LINES - 1);
  localparam logic [YW-1:0]     Y_SAT     = YW'(V_LINES);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_PIXELS);

  logic   cp_fall, unused_cp_rise, hs_rise, unused_hs_fall, vs_sync;
  pixel_t pix_sync;

  gb_sync_edge #(.STAGES(SYNC_STAGES), .DATA_W(2)) u_cp_sync (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (gb_cp),
    .data_i (gb_d),
    .rise_o (unused_cp_rise),
    .fall_o (cp_fall),
    .data_o (pix_sync)
  );

  gb_sync_edge #(.STAGES(SYNC_STAGES), .DATA_W(1)) u_hs_sync (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (gb_hs),
    .data_i (gb_vs),
    .rise_o (hs_rise),
    .fall_o (unused_hs_fall),
    .data_o (vs_sync)
  );

  logic   ev_fall_q, ev_rise_q, ev_vs_q;
  pixel_t ev_pix_q, pix_w;

  generate
    if (INVERT_DATA != 0) begin : g_invert
      assign pix_w = ~ev_pix_q;
    end else begin : g_plain
      assign pix_w = ev_pix_q;
    end
  endgenerate

  cap_state_e        state_q, state_d;
  logic [XW-1:0]     x_q, x_d, x_px;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] base_q, base_d, wr_addr_q, wr_addr_d;
  pixel_t            wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d, frame_done_q, frame_done_d;
  logic              line_err_q, line_err_d, frame_err_q, frame_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      ev_fall_q    <= 1'b0;
      ev_rise_q    <= 1'b0;
      ev_vs_q      <= 1'b0;
      ev_pix_q     <= '0;
      state_q      <= WAIT_FRAME;
      x_q          <= '0;
      y_q          <= '0;
      base_q       <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      ev_fall_q    <= cp_fall;
      ev_rise_q    <= hs_rise;
      ev_vs_q      <= vs_sync;
      ev_pix_q     <= pix_sync;
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      base_q       <= base_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      frame_done_q <= frame_done_d;
      line_err_q   <= line_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    x_px         = x_q;
    y_d          = y_q;
    base_d       = base_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    line_err_d   = line_err_q & ~err_clr;
    frame_err_d  = frame_err_q & ~err_clr;

    case (state_q)
      WAIT_FRAME: begin
        if (ev_rise_q && ev_vs_q) begin
          x_d     = '0;
          y_d     = '0;
          base_d  = '0;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (ev_fall_q) begin
          if (x_q < X_FULL && y_q < Y_SAT) begin
            wr_en_d   = 1'b1;
            wr_addr_d = base_q + ADDR_W'(x_q);
            wr_data_d = pix_w;
          end
          if (x_q != X_SAT) x_px = x_q + 1'b1;
        end
        x_d = x_px;
        // a coincident pixel has already advanced x_px, so the length check sees it
        if (ev_rise_q) begin
          if (x_px != X_FULL) line_err_d = 1'b1;
          x_d = '0;
          if (ev_vs_q) begin
            if (y_q == Y_LAST) frame_done_d = 1'b1;
            else               frame_err_d  = 1'b1;
            y_d    = '0;
            base_d = '0;
          end else if (y_q != Y_SAT) begin
            y_d    = y_q + 1'b1;
            base_d = base_q + LINE_STEP;
            if (y_q == Y_LAST) frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = WAIT_FRAME;
    endcase
  end

  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_en      = wr_en_q;
  assign frame_done = frame_done_q;
  assign capturing  = (state_q == ACTIVE);
  assign line_err   = line_err_q;
  assign frame_err  = frame_err_q;

endmodule : gb_lcd_capture
`default_nettype wire

// File: tb/tb_gb_lcd_capture.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_gb_lcd_capture : randomised LCD bus stimulus checked against a line/pixel model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_gb_lcd_capture;

  localparam int S      = 2;
  localparam int SETTLE = S + 5;

  logic        clk = 1'b0, rst = 1'b1;
  logic        gb_cp = 1'b0, gb_hs = 1'b0, gb_vs = 1'b0, err_clr = 1'b0;
  logic [1:0]  gb_d = 2'b00;
  logic [14:0] wr_addr;
  logic [1:0]  wr_data;
  logic        wr_en, frame_done, capturing, line_err, frame_err;

  always #5 clk = ~clk;

  gb_lcd_capture #(
    .H_PIXELS(160), .V_LINES(144), .ADDR_W(15), .SYNC_STAGES(S), .INVERT_DATA(1)
  ) dut (
    .clk(clk), .rst(rst), .gb_cp(gb_cp), .gb_hs(gb_hs), .gb_vs(gb_vs), .gb_d(gb_d),
    .err_clr(err_clr), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .frame_done(frame_done), .capturing(capturing), .line_err(line_err), .frame_err(frame_err)
  );

  int checks = 0, errors = 0;
  int cyc = 0, last_evt = 0;
  int n_wr = 0, dut_done = 0, last_addr = -1;
  logic [1:0] last_data = 2'b00;
  logic prev_fd = 1'b0;

  // reference: position (mx,my) in the frame, address = my*160 + mx
  typedef struct { int addr; logic [1:0] data; } wr_t;
  wr_t exp_q[$];
  bit  m_active = 1'b0, m_lerr = 1'b0, m_ferr = 1'b0;
  int  mx = 0, my = 0, m_done = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_pixel(input logic [1:0] d);
    wr_t w;
    if (m_active) begin
      if (mx < 160 && my < 144) begin
        w.addr = my * 160 + mx;
        w.data = ~d;
        exp_q.push_back(w);
      end
      if (mx < 161) mx++;
    end
  endtask

  task automatic model_hs(input bit vs);
    if (!m_active) begin
      if (vs) begin m_active = 1'b1; mx = 0; my = 0; end
    end else begin
      if (mx != 160) m_lerr = 1'b1;
      mx = 0;
      if (vs) begin
        if (my == 143) m_done++; else m_ferr = 1'b1;
        my = 0;
      end else if (my < 144) begin
        if (my == 143) m_ferr = 1'b1;
        my++;
      end
    end
  endtask

  task automatic cp_pix(input logic [1:0] d, input int hi, input int lo);
    @(negedge clk); gb_d = d; gb_cp = 1'b1;
    repeat (hi) @(negedge clk);
    gb_cp = 1'b0; model_pixel(d); last_evt = cyc;
    repeat (lo - 1) @(negedge clk);
  endtask

  task automatic hs_pulse(input bit vs, input int hi, input int lo);
    @(negedge clk); gb_vs = vs; gb_hs = 1'b1; model_hs(vs); last_evt = cyc;
    repeat (hi) @(negedge clk);
    gb_hs = 1'b0; gb_vs = 1'b0;
    repeat (lo - 1) @(negedge clk);
  endtask

  task automatic cp_hs_same(input logic [1:0] d, input bit vs);
    @(negedge clk); gb_d = d; gb_cp = 1'b1;
    repeat (2) @(negedge clk);
    gb_cp = 1'b0; gb_hs = 1'b1; gb_vs = vs;
    model_pixel(d); model_hs(vs); last_evt = cyc;
    repeat (2) @(negedge clk);
    gb_hs = 1'b0; gb_vs = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic cp_pix_lat(input logic [1:0] d);
    int lat;
    lat = 0;
    @(negedge clk); gb_d = d; gb_cp = 1'b1;
    repeat (2) @(negedge clk);
    gb_cp = 1'b0; model_pixel(d); last_evt = cyc;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #2;
      if (wr_en) begin lat = k; break; end
    end
    chk("wr_en_latency_edges", lat, S + 3);
  endtask

  task automatic wait_settle();
    repeat (SETTLE + 3) @(negedge clk);
  endtask

  task automatic clr_err();
    @(negedge clk); err_clr = 1'b1; m_lerr = 1'b0; m_ferr = 1'b0; last_evt = cyc;
    @(negedge clk); err_clr = 1'b0;
    wait_settle();
  endtask

  task automatic do_reset();
    chk("queue_empty_before_reset", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk); rst = 1'b1;
    m_active = 1'b0; m_lerr = 1'b0; m_ferr = 1'b0; mx = 0; my = 0; last_evt = cyc;
    @(posedge clk); #3;
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_capturing", capturing, 0);
    chk("rst_line_err", line_err, 0);
    chk("rst_frame_err", frame_err, 0);
    @(negedge clk); rst = 1'b0; last_evt = cyc;
  endtask

  // every-cycle compare against the model
  initial begin
    wr_t e;
    forever begin
      @(posedge clk); #2;
      cyc++;
      if (wr_en) begin
        n_wr++; last_addr = int'(wr_addr); last_data = wr_data;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write actual_addr=%0d required=no_write (cycle %0d)", wr_addr, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", wr_addr, e.addr);
          chk("wr_data", wr_data, e.data);
        end
      end
      if (frame_done) begin
        dut_done++;
        chk("frame_done_single_cycle", prev_fd, 0);
      end
      prev_fd = frame_done;
      if (!rst && (cyc - last_evt) > SETTLE) begin
        chk("line_err", line_err, m_lerr);
        chk("frame_err", frame_err, m_ferr);
        chk("capturing", capturing, m_active);
      end
    end
  end

  initial begin
    int w0, d0, nl, np;
    bit same, v;
    repeat (3) @(negedge clk);
    do_reset();

    // 1: no frame start -> nothing written
    repeat (20) cp_pix(2'($urandom), $urandom_range(1, 3), $urandom_range(1, 3));
    wait_settle();
    chk("t1_no_writes", n_wr, 0);
    chk("t1_capturing", capturing, 0);
    chk("t1_line_err", line_err, 0);
    chk("t1_frame_err", frame_err, 0);

    // 2: one full frame, gb_d = x[1:0]
    hs_pulse(1'b1, 1, 1);
    wait_settle();
    w0 = n_wr; d0 = dut_done;
    for (int y = 0; y < 144; y++) begin
      for (int x = 0; x < 160; x++) begin
        if (y == 0 && x == 0) cp_pix_lat(2'b00);
        else                  cp_pix(2'(x), 1, 1);
      end
      hs_pulse(y == 143, 1, 1);
    end
    wait_settle();
    chk("t2_write_count", n_wr - w0, 23040);
    chk("t2_last_addr", last_addr, 23039);
    chk("t2_last_data", last_data, 0);
    chk("t2_frame_done_count", dut_done - d0, 1);
    chk("t2_line_err", line_err, 0);
    chk("t2_frame_err", frame_err, 0);

    // 3: over-long line
    w0 = n_wr;
    for (int x = 0; x < 162; x++) cp_pix(2'($urandom), 1, 1);
    hs_pulse(1'b0, 1, 1);
    wait_settle();
    chk("t3_line_writes", n_wr - w0, 160);
    cp_pix(2'($urandom), 1, 1);
    wait_settle();
    chk("t3_next_line_addr", last_addr, 160);
    chk("t3_line_err_set", line_err, 1);
    clr_err();
    chk("t3_line_err_clr", line_err, 0);

    // 4: 145 lines before vs
    hs_pulse(1'b1, 1, 1);
    wait_settle();
    clr_err();
    chk("t4_frame_err_clean", frame_err, 0);
    for (int y = 0; y < 144; y++) begin
      cp_pix(2'($urandom), 1, 1); cp_pix(2'($urandom), 1, 1);
      hs_pulse(1'b0, 1, 1);
      if (y == 142) begin
        wait_settle();
        chk("t4_frame_err_line143", frame_err, 0);
      end
    end
    wait_settle();
    chk("t4_frame_err_set", frame_err, 1);
    w0 = n_wr;
    cp_pix(2'($urandom), 1, 1); cp_pix(2'($urandom), 1, 1);
    hs_pulse(1'b1, 1, 1);
    wait_settle();
    chk("t4_line144_no_writes", n_wr - w0, 0);
    cp_pix(2'($urandom), 1, 1);
    wait_settle();
    chk("t4_new_frame_addr", last_addr, 0);

    // 5: reset at line 50, pixel 30
    for (int y = 0; y < 50; y++) begin
      cp_pix(2'($urandom), 1, 1);
      hs_pulse(1'b0, 1, 1);
    end
    for (int x = 0; x < 30; x++) cp_pix(2'($urandom), 1, 1);
    wait_settle();
    chk("t5_addr_before_reset", last_addr, 50 * 160 + 29);
    do_reset();
    w0 = n_wr;
    repeat (10) cp_pix(2'($urandom), 1, 2);
    wait_settle();
    chk("t5_no_writes_after_reset", n_wr - w0, 0);
    hs_pulse(1'b1, 1, 1);
    cp_pix(2'($urandom), 1, 1);
    wait_settle();
    chk("t5_restart_addr", last_addr, 0);
    chk("t5_capturing", capturing, 1);

    // 6: last pixel of a line coincides with hs
    hs_pulse(1'b0, 1, 1);
    wait_settle();
    clr_err();
    for (int x = 0; x < 159; x++) cp_pix(2'($urandom), 1, 1);
    cp_hs_same(2'($urandom), 1'b0);
    wait_settle();
    chk("t6_same_cycle_addr", last_addr, 319);
    chk("t6_line_err", line_err, 0);
    cp_pix(2'($urandom), 1, 1);
    wait_settle();
    chk("t6_next_line_addr", last_addr, 320);

    // randomised frames of mixed line lengths and timing
    for (int f = 0; f < 3; f++) begin
      hs_pulse(1'b1, 1, 1);
      wait_settle();
      clr_err();
      nl = $urandom_range(2, 5);
      for (int l = 0; l < nl; l++) begin
        np   = 158 + $urandom_range(0, 4);
        same = ($urandom_range(0, 3) == 0);
        for (int p = 0; p < np - (same ? 1 : 0); p++)
          cp_pix(2'($urandom), $urandom_range(1, 3), $urandom_range(1, 3));
        v = ($urandom_range(0, 5) == 0);
        if (same) cp_hs_same(2'($urandom), v);
        else      hs_pulse(v, $urandom_range(1, 3), $urandom_range(1, 3));
      end
      wait_settle();
    end

    chk("exp_queue_drained", exp_q.size(), 0);
    chk("frame_done_total", dut_done, m_done);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_gb_lcd_capture
`default_nettype wire

// File: doc/gb_lcd_capture.md
Name: gb_lcd_capture

Overview:
- Samples the Game Boy LCD bus: pixel clock, line latch, frame sync and 2-bit pixel data. All four are asynchronous to the system clock.
- Counts pixels and lines, and emits write address, data and enable for the write port of the 160x144x2bpp framebuffer.
- The VGA scan-out stage reads that same framebuffer at address = line*160 + pixel.
- Sits between the Game Boy connector pins and the framebuffer write port.

Parameters:
- H_PIXELS, 160: pixels per line.
- V_LINES, 144: lines per frame.
- ADDR_W, 15: framebuffer address width.
- SYNC_STAGES, 2: flip-flop stages in the input synchroniser (minimum 2).
- INVERT_DATA, 1: when 1, wr_data = ~pixel. Game Boy 2'b11 is darkest; the framebuffer convention is 2'b11 = brightest.

Ports:
- clk  in  1  system clock (the PLL clock used by the VGA side); at least 8x the Game Boy pixel clock.
- rst  in  1  synchronous, active-high reset.
- gb_cp  in  1  LCD pixel clock (async); data is valid on its falling edge.
- gb_hs  in  1  LCD line latch (async); rising edge ends a line.
- gb_vs  in  1  LCD frame sync (async); high during the first line latch of a frame.
- gb_d  in  2  LCD pixel data (async).
- err_clr  in  1  clears the sticky error flags.
- wr_addr  out  ADDR_W  framebuffer write address.
- wr_data  out  2  framebuffer write data.
- wr_en  out  1  framebuffer write strobe, one clk cycle per pixel.
- frame_done  out  1  one-cycle pulse when a complete frame has been captured.
- capturing  out  1  high while in state ACTIVE.
- line_err  out  1  sticky: a line ended with pixel count != H_PIXELS.
- frame_err  out  1  sticky: a frame ended with line count != V_LINES, or more than V_LINES lines arrived.

Behaviour:
- Synchronisation and edge detection
  - gb_cp, gb_hs, gb_vs and gb_d pass through identical SYNC_STAGES-deep flip-flop chains, plus one extra stage for edge detection.
  - cp_fall = previous synced cp high and current synced cp low. hs_rise is detected the same way on gb_hs.
  - The data used for a pixel is the synced gb_d from the same stage as the cp sample that produced cp_fall.
- Latency: wr_en is registered. It asserts exactly SYNC_STAGES+2 clk cycles after the first clk edge that samples gb_cp low.
- Reset (rst=1 at a clk edge)
  - Next cycle: wr_addr=0, wr_data=0, wr_en=0, frame_done=0, capturing=0, line_err=0, frame_err=0.
  - Pixel counter x=0, line counter y=0, line base register=0, state=WAIT_FRAME, synchroniser flops cleared to 0.
  - Reset mid-frame aborts the frame; no writes occur until a new frame start.
- State WAIT_FRAME
  - cp_fall is ignored.
  - hs_rise with synced vs=1 sets x=0, y=0, base=0 and moves to ACTIVE. This does not set frame_done or any error flag.
- State ACTIVE, on cp_fall
  - If x < H_PIXELS and y < V_LINES: wr_en=1, wr_addr=base+x, wr_data=pixel (inverted if INVERT_DATA).
  - Otherwise the pixel is dropped.
  - x saturates at H_PIXELS+1.
- State ACTIVE, on hs_rise
  - If x != H_PIXELS, set line_err.
  - Then x=0.
  - If synced vs=1 (frame start):
    - If y == V_LINES-1, pulse frame_done; otherwise set frame_err.
    - Then y=0, base=0.
  - Otherwise:
    - y = y+1, saturating at V_LINES.
    - base = base + H_PIXELS, held once y reaches V_LINES.
    - Incrementing y from V_LINES-1 to V_LINES sets frame_err.
- cp_fall and hs_rise in the same cycle: the pixel is handled first, using the pre-update x and base; the counters then update as for hs_rise.
- No multiplier: the address is formed as base + x. The maximum address is 23039 (0x59FF).
- err_clr clears line_err and frame_err on the next cycle. If an error event occurs in the same cycle, the set wins.
- capturing = (state == ACTIVE).

Decomposition:
- Shared package gb_pkg:
  - GB_H_PIXELS=160, GB_V_LINES=144, FB_ADDR_W=15, FB_DEPTH=23040.
  - Pixel type (2-bit).
  - Capture state enum {WAIT_FRAME, ACTIVE}.
  - The VGA scan-out block uses the same constants.
- Sub-module gb_sync_edge: a SYNC_STAGES synchroniser plus rise/fall detector. It is instantiated for cp and hs; the vs and data lanes reuse its synchroniser chain without the detector.

Test Plan:
1. Reset, then 20 CP pulses with vs=0 and no hs -> wr_en never asserts, capturing=0, all flags 0.
2. Full frame: hs with vs=1, then 144 lines of 160 CP pulses with gb_d = x[1:0], each line ended by hs, and a final hs with vs=1.
   - Expect 23040 writes with wr_addr 0..23039 in order, and wr_data = ~(addr mod 160)[1:0].
   - frame_done pulses once, on the final hs; line_err=0, frame_err=0.
3. One line of 162 CP pulses -> pixels 160 and 161 are not written, the next line starts at addr 160*(y+1), line_err=1. err_clr pulse -> line_err=0.
4. 145 lines before vs -> line 144 produces no writes, frame_err=1, and the next frame starts at addr 0.
5. rst asserted at line 50, pixel 30 -> all outputs 0 on the next cycle; CP pulses before the next vs-qualified hs produce no writes; the new frame restarts at addr 0.
6. cp_fall and hs_rise in the same clk cycle at x=159 -> the write goes to base+159; the next pixel goes to base+160, i.e. x=0 of the next line; line_err stays 0.
